// File: rtl/conv_out_pkg.sv
// Shared types for the convolution output packer.
// State encoding, default widths and the result entry layout.
package conv_out_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 12;
  localparam int LANES      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/conv_out_packer_fifo.sv
// Result FIFO: one write port, a 4-entry read window
// starting at the oldest entry, and a pop of 0..4 entries.
module out_fifo_mr
  import conv_out_pkg::*;
#(
  parameter int EW    = 20,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [EW-1:0]              wr_entry,
  input  logic [2:0]                 pop_n,
  output logic [LANES-1:0][EW-1:0]   rd_win,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q + PW'(pop_n);
    cnt_d = cnt_q + CW'(push) - CW'(pop_n);
    if (push) begin
      mem_d[wp_q] = wr_entry;
      wp_d        = wp_q + PW'(1);
    end
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end
  end

  // Pointer arithmetic is PW bits wide, so the window wraps for free.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      rd_win[k] = mem_q[rp_q + PW'(k)];
    end
  end

  assign cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_out_packer.sv
// Packs the single-lane engine result stream onto four
// registered output lanes, oldest result on lane 1.
module conv_out_packer
  import conv_out_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_last,
  output logic              o_ready,
  input  logic              i_hold,
  output logic [DATA_W-1:0] o_out_data1,
  output logic [DATA_W-1:0] o_out_data2,
  output logic [DATA_W-1:0] o_out_data3,
  output logic [DATA_W-1:0] o_out_data4,
  output logic [ADDR_W-1:0] o_out_addr1,
  output logic [ADDR_W-1:0] o_out_addr2,
  output logic [ADDR_W-1:0] o_out_addr3,
  output logic [ADDR_W-1:0] o_out_addr4,
  output logic              o_out_valid1,
  output logic              o_out_valid2,
  output logic              o_out_valid3,
  output logic              o_out_valid4,
  output logic              o_done
);

  localparam int EW = ADDR_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] GRP  = CW'(LANES);

  state_e state_q, state_d;
  logic   last_seen_q, last_seen_d;
  logic   done_q, done_d;
  logic [LANES-1:0]         vld_q, vld_d;
  logic [LANES-1:0][EW-1:0] lane_q, lane_d;
  logic [LANES-1:0][EW-1:0] rd_win;
  logic [CW-1:0]            cnt;
  logic [2:0]               npop;
  logic                     push;

  assign o_ready = (state_q == RUN) && (cnt < FULL);
  assign push    = i_valid && o_ready && !i_start;

  out_fifo_mr #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .clr      (i_start),
    .push     (push),
    .wr_entry ({i_addr, i_data}),
    .pop_n    (npop),
    .rd_win   (rd_win),
    .cnt      (cnt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      last_seen_q <= 1'b0;
      done_q      <= 1'b0;
      vld_q       <= '0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_seen_q <= last_seen_d;
      done_q      <= done_d;
      vld_q       <= vld_d;
      lane_q      <= lane_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_seen_d = last_seen_q;
    if (i_start) begin
      state_d     = RUN;
      last_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (last_seen_q || (push && i_last)) begin
            last_seen_d = 1'b1;
            state_d     = FLUSH;
          end
        end
        FLUSH: if (cnt == '0) state_d = DONE;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pop decisions use the registered count only, so a same-cycle
  // push never joins the group being popped.
  always_comb begin
    npop = 3'd0;
    if (!i_start && !i_hold) begin
      if (state_q == RUN && cnt >= GRP) begin
        npop = 3'd4;
      end else if (state_q == FLUSH && cnt != '0) begin
        npop = (cnt >= GRP) ? 3'd4 : cnt[2:0];
      end
    end
    for (int k = 0; k < LANES; k++) begin
      vld_d[k]  = 3'(k) < npop;
      lane_d[k] = vld_d[k] ? rd_win[k] : '0;
    end
    done_d = (state_d == DONE);
  end

  assign o_done       = done_q;
  assign o_out_valid1 = vld_q[0];
  assign o_out_valid2 = vld_q[1];
  assign o_out_valid3 = vld_q[2];
  assign o_out_valid4 = vld_q[3];
  assign o_out_addr1  = lane_q[0][EW-1:DATA_W];
  assign o_out_addr2  = lane_q[1][EW-1:DATA_W];
  assign o_out_addr3  = lane_q[2][EW-1:DATA_W];
  assign o_out_addr4  = lane_q[3][EW-1:DATA_W];
  assign o_out_data1  = lane_q[0][DATA_W-1:0];
  assign o_out_data2  = lane_q[1][DATA_W-1:0];
  assign o_out_data3  = lane_q[2][DATA_W-1:0];
  assign o_out_data4  = lane_q[3][DATA_W-1:0];

endmodule

// File: tb/tb_conv_out_packer.sv
// Self-checking bench for conv_out_packer: table vectors,
// directed corner sequences and random traffic against a queue model.
module tb_conv_out_packer;
  import conv_out_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, valid = 1'b0, last = 1'b0, hold = 1'b0;
  logic [DW-1:0] data = '0;
  logic [AW-1:0] addr = '0;

  logic o_ready, o_done;
  logic [DW-1:0] od1, od2, od3, od4;
  logic [AW-1:0] oa1, oa2, oa3, oa4;
  logic ov1, ov2, ov3, ov4;

  conv_out_packer #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_valid      (valid),
    .i_data       (data),
    .i_addr       (addr),
    .i_last       (last),
    .o_ready      (o_ready),
    .i_hold       (hold),
    .o_out_data1  (od1),
    .o_out_data2  (od2),
    .o_out_data3  (od3),
    .o_out_data4  (od4),
    .o_out_addr1  (oa1),
    .o_out_addr2  (oa2),
    .o_out_addr3  (oa3),
    .o_out_addr4  (oa4),
    .o_out_valid1 (ov1),
    .o_out_valid2 (ov2),
    .o_out_valid3 (ov3),
    .o_out_valid4 (ov4),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of accepted results and a job phase
  // (0 idle, 1 running, 2 flushing, 3 done).
  entry_t   mq[$];
  int       ph = 0;
  logic [3:0] e_vld = '0;
  entry_t   e_ln[4];
  logic     e_done = 1'b0;
  bit       acc;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] dut_lanes();
    return {44'd0, ov4, ov3, ov2, ov1,
            oa1, od1, oa2, od2, oa3, od3, oa4, od4};
  endfunction

  function automatic logic [127:0] exp_lanes();
    return {44'd0, e_vld, e_ln[0], e_ln[1], e_ln[2], e_ln[3]};
  endfunction

  task automatic model_reset();
    mq.delete();
    ph     = 0;
    e_vld  = '0;
    e_done = 1'b0;
    for (int k = 0; k < 4; k++) e_ln[k] = '0;
  endtask

  // One clock: predict from current inputs, clock, then compare.
  task automatic cyc(input string tag);
    bit rdy;
    int n, sz, nph;
    rdy = (ph == 1) && (mq.size() < DEPTH);
    chk({tag, ".ready"}, o_ready, rdy);
    acc   = 0;
    e_vld = '0;
    for (int k = 0; k < 4; k++) e_ln[k] = '0;
    if (start) begin
      mq.delete();
      nph = 1;
    end else begin
      sz  = mq.size();
      n   = 0;
      nph = ph;
      if (!hold && ph == 1 && sz >= 4) n = 4;
      else if (!hold && ph == 2 && sz > 0) n = (sz < 4) ? sz : 4;
      for (int k = 0; k < n; k++) begin
        e_vld[k] = 1'b1;
        e_ln[k]  = mq.pop_front();
      end
      if (ph == 2 && sz == 0) nph = 3;
      if (ph == 3) nph = 0;
      if (valid && rdy) begin
        acc = 1;
        mq.push_back(entry_t'({addr, data}));
        if (last) nph = 2;
      end
    end
    ph     = nph;
    e_done = (nph == 3);
    @(posedge clk);
    #1;
    chk({tag, ".lanes"}, dut_lanes(), exp_lanes());
    chk({tag, ".done"}, o_done, e_done);
    @(negedge clk);
  endtask

  task automatic push_item(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit l, input string tag);
    bit ok;
    ok    = 0;
    valid = 1'b1;
    addr  = a;
    data  = d;
    last  = l;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc(tag);
      ok = acc;
    end
    chk({tag, ".accepted"}, ok, 1);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc(tag);
      if (ov1 && oa1 == AW'(24))
        chk({tag, ".tail_lanes"}, {ov2, ov3, ov4, oa2, od2, oa3, od3, oa4, od4}, 0);
      got = o_done;
    end
    chk({tag, ".done_seen"}, got, 1);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    cyc(tag);
    start = 1'b0;
  endtask

  typedef struct {
    bit            st, v, l, h;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    ev;
    logic [AW-1:0] ea1;
    bit            edn;
  } vec_t;

  vec_t tbl[12];

  initial begin
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst0.ready", o_ready, 0);
    chk("rst0.lanes", dut_lanes(), 0);
    chk("rst0.done", o_done, 0);
    rst = 1'b0;
    cyc("idle");

    // Full groups: addr 0..7, data 10..17, last on the 8th
    for (int i = 0; i < 12; i++) begin
      tbl[i] = '{st: (i == 0), v: (i >= 1 && i <= 8), l: (i == 8), h: 0,
                 a: AW'(i - 1), d: DW'(i + 9), ev: 4'h0, ea1: '0, edn: 0};
    end
    tbl[5].ev  = 4'hF;
    tbl[5].ea1 = AW'(0);
    tbl[9].ev  = 4'hF;
    tbl[9].ea1 = AW'(4);
    tbl[10].edn = 1;
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st;
      valid = tbl[i].v;
      last  = tbl[i].l;
      hold  = tbl[i].h;
      addr  = tbl[i].a;
      data  = tbl[i].d;
      cyc("tbl");
      chk($sformatf("tbl%0d.vmask", i), {ov4, ov3, ov2, ov1}, tbl[i].ev);
      chk($sformatf("tbl%0d.addr1", i), ov1 ? oa1 : '0, tbl[i].ea1);
      chk($sformatf("tbl%0d.done", i), o_done, tbl[i].edn);
    end
    start = 0;
    valid = 0;
    last  = 0;

    // Partial tail: 20..24
    do_start("tail");
    for (int i = 20; i <= 24; i++) push_item(AW'(i), DW'(i + 1), i == 24, "tail");
    wait_done("tail");

    // Hold / backpressure
    do_start("hold");
    hold = 1'b1;
    for (int i = 0; i < 8; i++) push_item(AW'(i), DW'(i + 1), 0, "hold");
    valid = 1'b1;
    addr  = AW'(8);
    data  = DW'(9);
    repeat (3) cyc("hold.full");
    chk("hold.ready_low", o_ready, 0);
    hold = 1'b0;
    for (int i = 8; i < 12; i++) push_item(AW'(i), DW'(i + 1), i == 11, "hold");
    wait_done("hold");

    // Restart with 3 stale entries in the FIFO
    do_start("restart");
    for (int i = 50; i < 53; i++) push_item(AW'(i), DW'(i), 0, "restart");
    do_start("restart");
    for (int i = 100; i < 104; i++) push_item(AW'(i), DW'(i), i == 103, "restart");
    wait_done("restart");

    // Last on a group boundary with a 2-cycle hold
    do_start("bnd");
    for (int i = 200; i < 204; i++) push_item(AW'(i), DW'(i), i == 203, "bnd");
    hold = 1'b1;
    repeat (2) cyc("bnd.hold");
    chk("bnd.held_lanes", {ov4, ov3, ov2, ov1}, 0);
    hold = 1'b0;
    cyc("bnd.pop");
    chk("bnd.group", {ov4, ov3, ov2, ov1, oa1}, {4'hF, AW'(200)});
    wait_done("bnd");

    // Reset mid-RUN with 5 entries held
    do_start("mrst");
    hold = 1'b1;
    for (int i = 0; i < 5; i++) push_item(AW'(i + 60), DW'(i), 0, "mrst");
    rst = 1'b1;
    #1;
    chk("mrst.ready", o_ready, 0);
    chk("mrst.lanes", dut_lanes(), 0);
    chk("mrst.done", o_done, 0);
    model_reset();
    @(negedge clk);
    rst  = 1'b0;
    hold = 1'b0;
    chk("mrst.idle_ready", o_ready, 0);
    cyc("mrst.idle");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 29) == 0);
      valid = ($urandom_range(0, 9) < 7);
      last  = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 9) < 3);
      addr  = AW'($urandom);
      data  = DW'($urandom);
      cyc("rnd");
    end
    start = 0;
    valid = 0;
    last  = 0;
    hold  = 0;
    repeat (4) cyc("rnd.tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
